// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared register-file widths and address/data types.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter_if
// Brief    : Writeback request bus: per-requester valid/rd/wd and one-hot ready.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_rd;
    logic [N_REQ*DATA_W-1:0] req_wd;
    logic [N_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_rd,
        output req_wd,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rd,
        input  req_wd,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker; searches from ptr upward, wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin : p_pick
        logic             w_found;
        logic [IDX_W-1:0] w_cand;
        w_found   = 1'b0;
        w_cand    = '0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = IDX_W'((int'(ptr) + k) % N);
            if (!w_found && req[w_cand]) begin
                w_found       = 1'b1;
                grant[w_cand] = 1'b1;
                grant_idx     = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Shares the regfile write port between requesters; tracks pending
//            destination registers and reports source-operand stalls.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_wb_arbiter_if.slave    wb,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_rd,
    output logic [DATA_W-1:0]      rf_wd,
    input  logic                   rsv_valid,
    input  logic [ADDR_W-1:0]      rsv_rd,
    input  logic [ADDR_W-1:0]      q_rs,
    input  logic [ADDR_W-1:0]      q_rt,
    output logic                   stall,
    output logic [2**ADDR_W-1:0]   busy,
    output logic                   err_unrsv
);
    import regfile_pkg::*;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int NREGS = 2**ADDR_W;

    logic [IDX_W-1:0]  r_ptr;
    logic [N_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]  w_gidx;
    logic [IDX_W-1:0]  w_ptr_nxt;
    logic              w_commit;
    logic [ADDR_W-1:0] w_rd;
    logic [DATA_W-1:0] w_wd;
    logic [ADDR_W-1:0] w_rd_arr [N_REQ];
    logic [DATA_W-1:0] w_wd_arr [N_REQ];
    logic [NREGS-1:0]  w_busy_nxt;
    logic              w_err_set;

    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_rd;
    logic [DATA_W-1:0] r_rf_wd;
    logic [NREGS-1:0]  r_busy;
    logic              r_err;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign w_rd_arr[gi] = wb.req_rd[gi*ADDR_W +: ADDR_W];
        assign w_wd_arr[gi] = wb.req_wd[gi*DATA_W +: DATA_W];
    end

    // r_ptr holds the index searched first, i.e. one past the last grant.
    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req       (wb.req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_gidx)
    );

    assign wb.req_ready = w_grant & {N_REQ{rst_n}};
    assign w_commit     = |w_grant;
    assign w_rd         = w_rd_arr[w_gidx];
    assign w_wd         = w_wd_arr[w_gidx];
    assign w_ptr_nxt    = (w_gidx == IDX_W'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;
    assign w_err_set    = w_commit && (w_rd != '0) && !r_busy[w_rd];

    // Reservation applied after the clear so a same-cycle re-reserve survives.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_commit && (w_rd != '0)) begin
            w_busy_nxt[w_rd] = 1'b0;
        end
        if (rsv_valid && (rsv_rd != '0)) begin
            w_busy_nxt[rsv_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_rf_we <= 1'b0;
            r_rf_rd <= '0;
            r_rf_wd <= '0;
            r_busy  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_commit) begin
                r_ptr   <= w_ptr_nxt;
                r_rf_rd <= w_rd;
                r_rf_wd <= w_wd;
                r_rf_we <= (w_rd != '0);
            end else begin
                r_rf_we <= 1'b0;
            end
            r_busy <= w_busy_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rf_we     = r_rf_we;
    assign rf_rd     = r_rf_rd;
    assign rf_wd     = r_rf_wd;
    assign busy      = r_busy;
    assign err_unrsv = r_err;
    assign stall     = ((q_rs != '0) && r_busy[q_rs]) || ((q_rt != '0) && r_busy[q_rt]);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Brief    : Directed bench with a spec-level reference model and a regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.N_REQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb ();

    logic        rf_we;
    reg_addr_t   rf_rd;
    reg_data_t   rf_wd;
    logic        rsv_valid;
    reg_addr_t   rsv_rd, q_rs, q_rt;
    logic        stall;
    logic [31:0] busy;
    logic        err_unrsv;

    regfile_wb_arbiter #(.N_REQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb        (wb),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wd     (rf_wd),
        .rsv_valid (rsv_valid),
        .rsv_rd    (rsv_rd),
        .q_rs      (q_rs),
        .q_rt      (q_rt),
        .stall     (stall),
        .busy      (busy),
        .err_unrsv (err_unrsv)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // Register file sitting on the write port, written on the negedge.
    reg_data_t regs [NUM_REGS];
    always @(negedge clk) if (rf_we && rf_rd != 0) regs[rf_rd] <= rf_wd;

    // Reference model: last_m is the last granted index; search starts after it.
    logic [31:0] busy_m;
    logic        err_m, we_m;
    reg_addr_t   rd_m;
    reg_data_t   wd_m;
    int          last_m;

    function automatic int exp_grant(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : m_upd
        int        g;
        reg_addr_t a;
        reg_data_t d;
        if (!rst_n) begin
            busy_m <= '0; err_m <= 1'b0; we_m <= 1'b0; rd_m <= '0; wd_m <= '0;
            last_m <= N - 1;
        end else begin
            g = exp_grant(last_m, wb.req_valid);
            if (g >= 0) begin
                a = wb.req_rd[g*ADDR_W +: ADDR_W];
                d = wb.req_wd[g*DATA_W +: DATA_W];
                last_m <= g;
                rd_m   <= a;
                wd_m   <= d;
                we_m   <= (a != 0);
                if (a != 0) begin
                    if (!busy_m[a]) err_m <= 1'b1;
                    busy_m[a] <= 1'b0;
                end
            end else begin
                we_m <= 1'b0;
            end
            if (rsv_valid && rsv_rd != 0) busy_m[rsv_rd] <= 1'b1;
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin : cmp
        int          g;
        logic [N-1:0] er;
        g  = exp_grant(last_m, wb.req_valid);
        er = (rst_n && g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", wb.req_ready, er);
        chk("rf_we", rf_we, we_m);
        chk("rf_rd", rf_rd, rd_m);
        chk("rf_wd", rf_wd, wd_m);
        chk("busy", busy, busy_m);
        chk("err_unrsv", err_unrsv, err_m);
        chk("stall", stall, ((q_rs != 0) && busy_m[q_rs]) || ((q_rt != 0) && busy_m[q_rt]));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic setreq(input logic [N-1:0] v, input reg_addr_t rd0, input reg_data_t wd0,
                          input reg_addr_t rd1, input reg_data_t wd1);
        wb.req_valid = v;
        wb.req_rd    = {rd1, rd0};
        wb.req_wd    = {wd1, wd0};
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
        rsv_valid = 1'b0; rsv_rd = '0; q_rs = '0; q_rt = '0;
        setreq(2'b11, 5'd0, 32'h0, 5'd0, 32'h0);
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_ready", wb.req_ready, 2'b00);
        chk("rst_we", rf_we, 1'b0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_err", err_unrsv, 1'b0);

        rst_n = 1'b1;
        #1 chk("first_grant", wb.req_ready, 2'b01);
        tick();
        wb.req_valid = 2'b00;

        // Reserve r5, commit two cycles later.
        rsv_valid = 1'b1; rsv_rd = 5'd5; q_rs = 5'd5;
        tick();
        rsv_valid = 1'b0;
        #1 chk("stall_rsv", stall, 1'b1);
        tick();
        setreq(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        #1 chk("stall_commit", stall, 1'b1);
        chk("grant_r5", wb.req_ready, 2'b01);
        tick();
        wb.req_valid = 2'b00;
        #1 chk("stall_after", stall, 1'b0);
        chk("we_r5", rf_we, 1'b1);
        chk("rd_r5", rf_rd, 5'd5);
        chk("wd_r5", rf_wd, 32'hDEADBEEF);
        tick();
        #1 chk("we_once", rf_we, 1'b0);
        chk("regs_r5", regs[5], 32'hDEADBEEF);

        // Write to r0 is consumed without a regfile write.
        setreq(2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFFFFFF);
        #1 chk("grant_r0", wb.req_ready, 2'b10);
        tick();
        wb.req_valid = 2'b00;
        #1 chk("we_r0", rf_we, 1'b0);
        chk("err_r0", err_unrsv, 1'b0);
        tick();
        chk("regs_r0", regs[0], 32'h0);

        // Contention: grants alternate 0,1,0,1 with re-reservations.
        rsv_valid = 1'b1; rsv_rd = 5'd3; tick();
        rsv_rd = 5'd4; tick();
        setreq(2'b11, 5'd3, 32'd1, 5'd4, 32'd2);
        rsv_rd = 5'd3;
        #1 chk("alt_a", wb.req_ready, 2'b01);
        tick();
        setreq(2'b11, 5'd3, 32'd3, 5'd4, 32'd2);
        rsv_rd = 5'd4;
        #1 chk("alt_b", wb.req_ready, 2'b10);
        chk("busy3_rersv", busy[3], 1'b1);
        chk("wd_alt_a", rf_wd, 32'd1);
        tick();
        setreq(2'b11, 5'd3, 32'd3, 5'd4, 32'd4);
        rsv_valid = 1'b0;
        #1 chk("alt_c", wb.req_ready, 2'b01);
        chk("busy4_rersv", busy[4], 1'b1);
        tick();
        setreq(2'b10, 5'd3, 32'd3, 5'd4, 32'd4);
        #1 chk("alt_d", wb.req_ready, 2'b10);
        chk("busy3_clr", busy[3], 1'b0);
        tick();
        wb.req_valid = 2'b00;
        #1 chk("busy4_clr", busy[4], 1'b0);
        chk("wd_alt_d", rf_wd, 32'd4);

        // Same-cycle commit and re-reserve of r7.
        rsv_valid = 1'b1; rsv_rd = 5'd7; tick();
        setreq(2'b01, 5'd7, 32'd77, 5'd0, 32'h0);
        q_rt = 5'd7;
        tick();
        rsv_valid = 1'b0; wb.req_valid = 2'b00;
        #1 chk("busy7_kept", busy[7], 1'b1);
        chk("stall_r7", stall, 1'b1);
        chk("err_r7", err_unrsv, 1'b0);

        // Commit to unreserved r9 raises a sticky error.
        setreq(2'b10, 5'd0, 32'h0, 5'd9, 32'd99);
        tick();
        wb.req_valid = 2'b00;
        #1 chk("err_set", err_unrsv, 1'b1);
        tick(); tick();
        #1 chk("err_sticky", err_unrsv, 1'b1);

        // Asynchronous reset while a write is on the port.
        setreq(2'b01, 5'd7, 32'h55, 5'd0, 32'h0);
        tick();
        chk("we_pre_rst", rf_we, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk("we_async", rf_we, 1'b0);
        chk("busy_async", busy, 32'h0);
        chk("err_async", err_unrsv, 1'b0);
        chk("ready_async", wb.req_ready, 2'b00);
        tick(); tick();
        wb.req_valid = 2'b00;
        rst_n = 1'b1;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
